// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-channel TDM demultiplexer: serial input side plus
// the parallel channel outputs and status flags.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 8
);
  logic               din;
  logic               en;
  logic               fsync;
  logic [4*WIDTH-1:0] Q;
  logic [3:0]         vld;
  logic [1:0]         slot;
  logic               locked;
  logic               sync_err;

  // Driver of the serial stream / consumer of the channel words.
  modport master (
    output din, en, fsync,
    input  Q, vld, slot, locked, sync_err
  );

  // The demultiplexer itself.
  modport slave (
    input  din, en, fsync,
    output Q, vld, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive end of a 4-channel TDM serial link. Hunts for frame sync, then
// assembles WIDTH-bit slots MSB first and steers each completed word into
// its channel register with a one-cycle valid pulse. An fsync at any
// position other than the frame start resynchronises and flags sync_err.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux4_if.slave   bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StHunt, StRun} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [4*WIDTH-1:0] q_q, q_d;
  logic [3:0]         vld_q, vld_d;
  logic               sync_err_q, sync_err_d;

  logic [WIDTH-1:0]   word_next;
  logic               at_frame_start;

  assign word_next      = {shift_q[WIDTH-2:0], bus.din};
  assign at_frame_start = (slot_q == 2'd0) && (bit_cnt_q == '0);

  // Next-state: hunt for sync, then shift/count with resync on misplaced fsync.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    slot_d     = slot_q;
    shift_d    = shift_q;
    q_d        = q_q;
    vld_d      = 4'b0000;
    sync_err_d = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        StHunt: begin
          if (bus.fsync) begin
            state_d   = StRun;
            shift_d   = {{(WIDTH-1){1'b0}}, bus.din};
            bit_cnt_d = CntW'(1);
            slot_d    = 2'd0;
          end
        end
        StRun: begin
          if (bus.fsync && !at_frame_start) begin
            // Misplaced sync: drop the partial word, this bit starts slot 0.
            sync_err_d = 1'b1;
            shift_d    = {{(WIDTH-1){1'b0}}, bus.din};
            bit_cnt_d  = CntW'(1);
            slot_d     = 2'd0;
          end else if (bit_cnt_q == LastBit) begin
            q_d[slot_q*WIDTH +: WIDTH] = word_next;
            vld_d[slot_q]              = 1'b1;
            shift_d                    = word_next;
            bit_cnt_d                  = '0;
            slot_d                     = slot_q + 2'd1;
          end else begin
            shift_d   = word_next;
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHunt;
      bit_cnt_q  <= '0;
      slot_q     <= 2'd0;
      shift_q    <= '0;
      q_q        <= '0;
      vld_q      <= 4'b0000;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_q     <= slot_d;
      shift_q    <= shift_d;
      q_q        <= q_d;
      vld_q      <= vld_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.vld      = vld_q;
  assign bus.slot     = slot_q;
  assign bus.locked   = (state_q == StRun);
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=8). Expected channel words are
// queued when a slot is driven and popped when the DUT raises vld.
module tb_tdm_demux4;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  tdm_demux4_if #(.WIDTH(W)) bus ();

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] w;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  // Scoreboard monitor: every vld pulse must match the oldest queued word.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.sync_err === 1'b1) err_seen++;
      if (bus.vld !== 4'b0000) begin
        checks++;
        if ($countones(bus.vld) != 1 || sb.size() == 0) begin
          failures++;
          $display("FAIL vld_unexpected: got vld=%b, queued=%0d, required one-hot with queued word",
                   bus.vld, sb.size());
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          if (bus.vld !== (4'b0001 << e.ch) || bus.Q[e.ch*8 +: 8] !== e.w) begin
            failures++;
            $display("FAIL vld_word: got vld=%b Q=%h, required vld=%b word=%h",
                     bus.vld, bus.Q, 4'b0001 << e.ch, e.w);
          end
        end
      end
    end
  end

  // One bit on the serial line; returns 1 time unit after the consuming edge.
  task automatic send_bit(input logic b, input logic fs, input logic e);
    @(negedge clk);
    bus.din   = b;
    bus.fsync = fs;
    bus.en    = e;
    @(posedge clk);
    #1;
  endtask

  // One slot, MSB first; optional fsync on the first bit and en=0 gaps.
  task automatic send_word(input int ch, input logic [7:0] w, input bit fs_first,
                           input bit gaps);
    logic [4*W-1:0] q_before;
    sb_entry_t e;
    e.ch = ch;
    e.w  = w;
    sb.push_back(e);
    for (int i = 7; i >= 0; i--) begin
      if (gaps && i != 7) begin
        q_before = bus.Q;
        send_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.Q !== q_before || bus.vld !== 4'b0000 || bus.sync_err !== 1'b0) begin
          failures++;
          $display("FAIL en_low_hold: got Q=%h vld=%b err=%b, required Q=%h vld=0 err=0",
                   bus.Q, bus.vld, bus.sync_err, q_before);
        end
      end
      send_bit(w[i], fs_first && (i == 7), 1'b1);
      if (fs_first && i == 7) begin
        checks++;
        if (bus.locked !== 1'b1) begin
          failures++;
          $display("FAIL locked_after_sync: got %b, required 1", bus.locked);
        end
      end
    end
    checks++;
    if (bus.vld !== (4'b0001 << ch) || bus.slot !== 2'((ch + 1) % 4)) begin
      failures++;
      $display("FAIL slot_latency: got vld=%b slot=%0d, required vld=%b slot=%0d",
               bus.vld, bus.slot, 4'b0001 << ch, (ch + 1) % 4);
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input bit fs, input bit gaps);
    for (int c = 0; c < 4; c++) send_word(c, f[c*8 +: 8], fs && (c == 0), gaps);
  endtask

  task automatic check_q(input string name, input logic [31:0] exp_q);
    checks++;
    if (bus.Q !== exp_q) begin
      failures++;
      $display("FAIL %s: got Q=%h, required %h", name, bus.Q, exp_q);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.din   = 1'b0;
    bus.en    = 1'b0;
    bus.fsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.Q !== '0 || bus.vld !== 4'b0 || bus.slot !== 2'd0 || bus.locked !== 1'b0 ||
        bus.sync_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got Q=%h vld=%b slot=%0d locked=%b err=%b, required all 0",
               bus.Q, bus.vld, bus.slot, bus.locked, bus.sync_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    test_reset();
    send_frame(32'h01FF3CA5, 1'b1, 1'b0);
    check_q("basic_frame_q", 32'h01FF3CA5);
  endtask

  task automatic test_presync_ignored();
    test_reset();
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    checks++;
    if (bus.locked !== 1'b0 || bus.slot !== 2'd0 || bus.Q !== '0) begin
      failures++;
      $display("FAIL presync_hunt: got locked=%b slot=%0d Q=%h, required 0/0/0",
               bus.locked, bus.slot, bus.Q);
    end
    send_frame(32'h44332211, 1'b1, 1'b0);
    check_q("presync_frame_q", 32'h44332211);
  endtask

  task automatic test_en_gaps();
    int err0;
    test_reset();
    err0 = err_seen;
    send_frame(32'h01FF3CA5, 1'b1, 1'b1);
    check_q("en_gap_frame_q", 32'h01FF3CA5);
    checks++;
    if (err_seen !== err0) begin
      failures++;
      $display("FAIL en_gap_no_err: got %0d sync_err pulses, required 0", err_seen - err0);
    end
  endtask

  task automatic test_resync();
    int err0;
    err0 = err_seen;
    send_frame(32'h87654321, 1'b1, 1'b0);
    send_word(0, 8'h21, 1'b0, 1'b0);
    send_word(1, 8'h43, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b1);
    send_frame(32'hAA55F00F, 1'b1, 1'b0);
    checks++;
    if (err_seen !== err0 + 1) begin
      failures++;
      $display("FAIL resync_err_count: got %0d pulses, required 1", err_seen - err0);
    end
    check_q("resync_frame_q", 32'hAA55F00F);
  endtask

  task automatic test_back_to_back();
    int err0;
    err0 = err_seen;
    send_frame(32'h0C0B0A09, 1'b1, 1'b0);
    send_frame(32'h13579BDF, 1'b0, 1'b0);
    check_q("flywheel_q", 32'h13579BDF);
    checks++;
    if (err_seen !== err0 || bus.locked !== 1'b1) begin
      failures++;
      $display("FAIL flywheel_err: got %0d pulses locked=%b, required 0 pulses locked=1",
               err_seen - err0, bus.locked);
    end
  endtask

  task automatic test_mid_slot_reset();
    send_word(0, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.Q !== '0 || bus.vld !== 4'b0 || bus.locked !== 1'b0 || bus.slot !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: got Q=%h vld=%b locked=%b slot=%0d, required all 0",
               bus.Q, bus.vld, bus.locked, bus.slot);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    checks++;
    if (bus.locked !== 1'b0 || bus.Q !== '0) begin
      failures++;
      $display("FAIL post_reset_hunt: got locked=%b Q=%h, required 0/0", bus.locked, bus.Q);
    end
    send_frame(32'hDEADBEEF, 1'b1, 1'b0);
    check_q("post_reset_frame_q", 32'hDEADBEEF);
  endtask

  initial begin
    rst       = 1'b1;
    bus.din   = 1'b0;
    bus.en    = 1'b0;
    bus.fsync = 1'b0;
    test_reset();
    test_basic_frame();
    test_presync_ignored();
    test_en_gaps();
    test_resync();
    test_back_to_back();
    test_mid_slot_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d words never delivered, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer: the receiving end of a 4-channel TDM serial link.
- Accepts a serial bit stream framed by a frame-sync marker and steers each time slot into one of 4 parallel channel registers.
- Sits after the serial line interface; its outputs feed per-channel consumers, one valid pulse per completed slot.

Parameters:
- WIDTH, 8, bits per time slot (per channel word); legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- din  input  1  serial data bit, MSB of each slot first.
- en  input  1  bit strobe; din and fsync are sampled only on clk edges where en=1.
- fsync  input  1  frame sync; with en=1, marks the current din as bit MSB of slot 0.
- Q  output  4*WIDTH  channel words; Q[k*WIDTH +: WIDTH] = channel k, registered.
- vld  output  4  vld[k] is a one-cycle pulse when channel k's word updates.
- slot  output  2  slot index of the next expected bit.
- locked  output  1  1 while in RUN state.
- sync_err  output  1  one-cycle pulse on an unexpected fsync.

Behaviour:
- Reset: asynchronous. Q=0, vld=0, slot=0, locked=0, sync_err=0, bit counter=0, shift register=0, state=HUNT.
- States:
  - HUNT: all bits are ignored. On en=1 and fsync=1, the din is shifted in as bit 0 of slot 0, the bit counter becomes 1, and the state moves to RUN.
  - RUN: on each en=1, shift din into a WIDTH-bit shift register (shift left, LSB in), and increment the bit counter.
- Slot completion: when the bit counter reaches WIDTH-1 and en=1, the shift register plus the current din is written to channel[slot] on the same edge.
  - vld[slot] is 1 for exactly that next cycle.
  - The bit counter returns to 0 and slot increments mod 4 (3 wraps to 0).
- Latency: Q and vld update on the clock edge that samples the last bit of the slot; both are visible in the following cycle.
- Channels not being written hold their value indefinitely.
- en=0: no state change. Counters, shift register and outputs hold; vld=0 and sync_err=0.
- fsync in RUN at the expected position (slot=0, bit counter=0): normal; no error.
- fsync in RUN at any other position:
  - sync_err pulses for one cycle and the partial word is discarded (no vld).
  - That bit is taken as bit 0 of slot 0: slot=0, bit counter=1.
  - State stays RUN.
- fsync absent at frame start in RUN: flywheel. Counting continues; no error and no loss of lock.
- fsync coincident with a slot's last bit (not the expected position): the resync wins. No vld is issued and the partial word is discarded.
- At most one vld bit is set in any cycle.
- slot output: reflects the slot counter register. It is 0 in HUNT.
- locked: 0 in HUNT, 1 in RUN. Only rst returns the block to HUNT.
- rst mid-slot: everything clears immediately, without waiting for a clock; no vld is issued for the partial word.

Test Plan:
1. Reset, then en=1 continuously with fsync on the first bit; send 32 bits 0xA5,0x3C,0xFF,0x01 (MSB first) -> vld[0..3] pulse on cycles 8,16,24,32 after the sync bit; Q = 0x01_FF_3C_A5; locked=1 from the cycle after sync.
2. Bits before any fsync (16 random bits), then a frame 0x11,0x22,0x33,0x44 -> no vld during the pre-sync bits; Q = 0x44_33_22_11.
3. Same frame as 1 with en toggled 1,0,1,0… -> identical Q and vld sequence; each vld arrives after 8 en-qualified bits, and Q holds during en=0 cycles.
4. After one good frame, assert fsync at slot 2 bit 3 -> sync_err pulses once; no vld[2]; the following 32 bits 0x0F,0xF0,0x55,0xAA load into channels 0..3.
5. Two frames back-to-back with fsync only on the first -> the second frame lands correctly (flywheel); no sync_err.
6. Assert rst at slot 1 bit 4 -> Q=0, vld=0, locked=0 immediately; no output until the next fsync.
